// File: rtl/gpr_debug_pkg.sv
// Shared encodings for the debug-side register file initiator.
package gpr_debug_pkg;

  localparam int NUM_GPR   = 32;
  localparam int GPR_IDX_W = 5;
  localparam logic [GPR_IDX_W-1:0] LAST_IDX = GPR_IDX_W'(NUM_GPR - 1);

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_DUMP  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    EXEC,
    DUMP,
    CLEAR,
    RESP,
    RELEASE
  } state_e;

endpackage

// File: rtl/gpr_debug_port.sv
// Debug host initiator: halts the core, then reads/writes/dumps/clears the GPR file
// and returns results through a 1-deep response register on a valid/ready channel.
module gpr_debug_port
  import gpr_debug_pkg::*;
#(
  parameter int HALT_TIMEOUT = 255,
  parameter int TMO_W        = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [GPR_IDX_W-1:0] cmd_addr,
  input  logic [31:0]          cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [GPR_IDX_W-1:0] rsp_addr,
  output logic [31:0]          rsp_data,
  output logic                 rsp_last,
  output logic                 rsp_err,
  output logic                 halt_req,
  input  logic                 halt_ack,
  output logic [GPR_IDX_W-1:0] gpr_read_reg,
  input  logic [31:0]          gpr_read_data,
  output logic [GPR_IDX_W-1:0] gpr_write_reg,
  output logic [31:0]          gpr_write_data,
  output logic                 gpr_write_enable,
  output logic                 busy
);

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [GPR_IDX_W-1:0] addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic [GPR_IDX_W-1:0] idx_q, idx_d;
  logic                 halt_req_q, halt_req_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [GPR_IDX_W-1:0] rsp_addr_q, rsp_addr_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_last_q, rsp_last_d;
  logic                 rsp_err_q, rsp_err_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    idx_d      = idx_q;
    halt_req_d = halt_req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d       = op_e'(cmd_op);
          addr_d     = cmd_addr;
          data_d     = cmd_data;
          tmo_d      = '0;
          halt_req_d = 1'b1;
          rsp_last_d = 1'b0;
          rsp_err_d  = 1'b0;
          state_d    = HALT_WAIT;
        end
      end

      HALT_WAIT: begin
        if (halt_ack) begin
          case (op_q)
            OP_DUMP: begin
              idx_d   = '0;
              state_d = DUMP;
            end
            OP_CLEAR: begin
              idx_d   = GPR_IDX_W'(1);
              state_d = CLEAR;
            end
            default: state_d = EXEC;
          endcase
        end else if (tmo_q == TMO_W'(HALT_TIMEOUT - 1)) begin
          // The cycle that would bring the count to HALT_TIMEOUT aborts instead.
          rsp_valid_d = 1'b1;
          rsp_addr_d  = addr_q;
          rsp_data_d  = '0;
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_addr_d  = addr_q;
        rsp_last_d  = 1'b1;
        if (op_q == OP_READ) begin
          rsp_data_d = gpr_read_data;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_data_d = data_q;
          rsp_err_d  = (addr_q == '0);
        end
        state_d = RESP;
      end

      DUMP: begin
        if (rsp_valid_q && rsp_ready && rsp_last_q) begin
          rsp_valid_d = 1'b0;
          halt_req_d  = 1'b0;
          state_d     = RELEASE;
        end else if (!rsp_valid_q || rsp_ready) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = gpr_read_data;
          rsp_addr_d  = idx_q;
          rsp_last_d  = (idx_q == LAST_IDX);
          idx_d       = idx_q + GPR_IDX_W'(1);
        end
      end

      CLEAR: begin
        if (idx_q == LAST_IDX) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = '0;
          rsp_data_d  = 32'(NUM_GPR - 1);
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          idx_d = idx_q + GPR_IDX_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          halt_req_d  = 1'b0;
          state_d     = RELEASE;
        end
      end

      RELEASE: begin
        if (!halt_ack) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      idx_q       <= '0;
      halt_req_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      idx_q       <= idx_d;
      halt_req_q  <= halt_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Port drives decode from registered state so reset kills any strobe immediately.
  assign cmd_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign halt_req         = halt_req_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_addr         = rsp_addr_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_last         = rsp_last_q;
  assign rsp_err          = rsp_err_q;
  assign gpr_read_reg     = (state_q == DUMP) ? idx_q : addr_q;
  assign gpr_write_enable = (state_q == CLEAR) ||
                            ((state_q == EXEC) && (op_q == OP_WRITE) && (addr_q != '0));
  assign gpr_write_reg    = (state_q == CLEAR) ? idx_q : addr_q;
  assign gpr_write_data   = (state_q == CLEAR) ? 32'd0 : data_q;

endmodule

// File: tb/tb_gpr_debug_port.sv
// Directed bench for gpr_debug_port with a behavioural register file and halt responder.
module tb_gpr_debug_port;

  localparam int TMO = 255;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        halt_req;
  logic        halt_ack;
  logic [4:0]  gpr_read_reg;
  logic [31:0] gpr_read_data;
  logic [4:0]  gpr_write_reg;
  logic [31:0] gpr_write_data;
  logic        gpr_write_enable;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [31:0] rf [32];
  logic [2:0]  hist;
  bit          ack_en = 1'b1;
  bit          pl_en = 1'b0;
  int          pl_mode = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_mask = '0;

  always #5 clock = ~clock;

  gpr_debug_port #(.HALT_TIMEOUT(TMO), .TMO_W(8)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .gpr_read_reg(gpr_read_reg), .gpr_read_data(gpr_read_data),
    .gpr_write_reg(gpr_write_reg), .gpr_write_data(gpr_write_data),
    .gpr_write_enable(gpr_write_enable), .busy(busy)
  );

  // Core model: acks halt 3 cycles after the request, drops it 3 cycles after release.
  always @(posedge clock or posedge reset) begin
    if (reset) hist <= '0;
    else       hist <= {hist[1:0], halt_req};
  end
  assign halt_ack = ack_en & hist[2];

  assign gpr_read_data = rf[gpr_read_reg];

  always @(posedge clock) begin
    if (pl_en) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 0)             rf[i] = 32'd0;
        else if (pl_mode == 1)  rf[i] = 32'hA5A5A5A5;
        else                    rf[i] = 32'(i) * 32'h11;
      end
      if (pl_mode == 2) rf[5] = 32'hDEADBEEF;
      wr_cnt  = 0;
      wr_mask = '0;
    end else if (gpr_write_enable) begin
      wr_cnt = wr_cnt + 1;
      wr_mask[gpr_write_reg] = 1'b1;
      if (gpr_write_reg != 5'd0) rf[gpr_write_reg] = gpr_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int mode);
    @(negedge clock);
    pl_mode = mode;
    pl_en   = 1'b1;
    @(negedge clock);
    pl_en   = 1'b0;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic get_rsp(output logic [4:0] a, output logic [31:0] d, output logic l, output logic e);
    bit got = 1'b0;
    a = '0; d = '0; l = 1'b0; e = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clock);
      if (rsp_valid) begin
        a = rsp_addr; d = rsp_data; l = rsp_last; e = rsp_err;
        got = 1'b1;
      end
    end
    chk("rsp_arrived", {31'd0, got}, 32'd1);
    if (got) begin
      rsp_ready = 1'b1;
      @(negedge clock);
      rsp_ready = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 30 && !idle; i++) begin
      @(negedge clock);
      idle = cmd_ready;
    end
    chk("return_idle", {31'd0, idle}, 32'd1);
  endtask

  task automatic run_dump(input int mode, input int stop_beat, input bit toggle);
    int          beat = 0;
    bit          stalled = 1'b0;
    bit          rdy = 1'b0;
    logic [4:0]  s_addr = '0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [31:0] exp;
    for (int cyc = 0; cyc < 400 && beat < stop_beat; cyc++) begin
      @(negedge clock);
      if (stalled) begin
        chk("dump_stall_addr", {27'd0, rsp_addr}, {27'd0, s_addr});
        chk("dump_stall_data", rsp_data, s_data);
        chk("dump_stall_last", {31'd0, rsp_last}, {31'd0, s_last});
      end
      rdy = toggle ? ~rdy : 1'b1;
      rsp_ready = rdy;
      if (rsp_valid && rdy) begin
        exp = (mode == 0) ? 32'(beat) * 32'h11 : 32'd0;
        chk($sformatf("dump_addr_%0d", beat), {27'd0, rsp_addr}, 32'(beat));
        chk($sformatf("dump_data_%0d", beat), rsp_data, exp);
        chk($sformatf("dump_last_%0d", beat), {31'd0, rsp_last}, {31'd0, (beat == 31)});
        beat++;
        stalled = 1'b0;
      end else if (rsp_valid) begin
        stalled = 1'b1;
        s_addr = rsp_addr; s_data = rsp_data; s_last = rsp_last;
      end else begin
        stalled = 1'b0;
      end
    end
    chk("dump_beats", 32'(beat), 32'(stop_beat));
  endtask

  initial begin
    logic [4:0]  a;
    logic [31:0] d;
    logic        l, e;
    int          c0;
    int          n;

    // Reset state
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_halt_req", {31'd0, halt_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wen", {31'd0, gpr_write_enable}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // READ x5
    preload(2);
    send_cmd(2'b00, 5'd5, 32'd0);
    get_rsp(a, d, l, e);
    chk("read5_data", d, 32'hDEADBEEF);
    chk("read5_addr", {27'd0, a}, 32'd5);
    chk("read5_last", {31'd0, l}, 32'd1);
    chk("read5_err", {31'd0, e}, 32'd0);
    chk("read5_halt_drop", {31'd0, halt_req}, 32'd0);
    wait_idle();

    // WRITE x7 then READ x7
    c0 = wr_cnt;
    send_cmd(2'b01, 5'd7, 32'h12345678);
    get_rsp(a, d, l, e);
    chk("write7_data", d, 32'h12345678);
    chk("write7_err", {31'd0, e}, 32'd0);
    chk("write7_last", {31'd0, l}, 32'd1);
    chk("write7_strobes", 32'(wr_cnt - c0), 32'd1);
    wait_idle();
    send_cmd(2'b00, 5'd7, 32'd0);
    get_rsp(a, d, l, e);
    chk("read7_data", d, 32'h12345678);
    wait_idle();

    // WRITE x0 is rejected
    c0 = wr_cnt;
    send_cmd(2'b01, 5'd0, 32'hFFFFFFFF);
    get_rsp(a, d, l, e);
    chk("write0_err", {31'd0, e}, 32'd1);
    chk("write0_last", {31'd0, l}, 32'd1);
    chk("write0_strobes", 32'(wr_cnt - c0), 32'd0);
    wait_idle();
    send_cmd(2'b00, 5'd0, 32'd0);
    get_rsp(a, d, l, e);
    chk("read0_data", d, 32'd0);
    wait_idle();

    // DUMP with toggling back-pressure
    preload(0);
    send_cmd(2'b10, 5'd0, 32'd0);
    run_dump(0, 32, 1'b1);
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("dump_rsp_drop", {31'd0, rsp_valid}, 32'd0);
    chk("dump_halt_drop", {31'd0, halt_req}, 32'd0);
    wait_idle();

    // CLEAR then DUMP zeros
    preload(1);
    send_cmd(2'b11, 5'd0, 32'd0);
    get_rsp(a, d, l, e);
    chk("clear_data", d, 32'd31);
    chk("clear_last", {31'd0, l}, 32'd1);
    chk("clear_err", {31'd0, e}, 32'd0);
    chk("clear_strobes", 32'(wr_cnt), 32'd31);
    chk("clear_mask", wr_mask, 32'hFFFFFFFE);
    wait_idle();
    send_cmd(2'b10, 5'd0, 32'd0);
    run_dump(1, 32, 1'b0);
    @(negedge clock);
    rsp_ready = 1'b0;
    wait_idle();

    // Halt timeout on a WRITE
    ack_en = 1'b0;
    c0 = wr_cnt;
    send_cmd(2'b01, 5'd3, 32'hCAFEF00D);
    n = 0;
    while (!rsp_valid && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    chk("tmo_err", {31'd0, rsp_err}, 32'd1);
    chk("tmo_data", rsp_data, 32'd0);
    chk("tmo_last", {31'd0, rsp_last}, 32'd1);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("tmo_strobes", 32'(wr_cnt - c0), 32'd0);
    wait_idle();
    ack_en = 1'b1;

    // Reset in the middle of a DUMP
    preload(0);
    send_cmd(2'b10, 5'd0, 32'd0);
    run_dump(0, 10, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_halt_req", {31'd0, halt_req}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_wen", {31'd0, gpr_write_enable}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clock);
    rsp_ready = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    send_cmd(2'b00, 5'd9, 32'd0);
    get_rsp(a, d, l, e);
    chk("post_rst_read_data", d, 32'h99);
    chk("post_rst_read_addr", {27'd0, a}, 32'd9);
    chk("post_rst_read_err", {31'd0, e}, 32'd0);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
